// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared types, constants and helpers for the multi-channel clock divider
package clkdiv_pkg;
   localparam int DIV_W_DEF = 16;
   localparam int DIV_MIN = 2;
   typedef logic [DIV_W_DEF-1:0] div_t;
   typedef enum logic {STOP, RUN} ch_state_t;
   function automatic logic [31:0] half_up(input logic [31:0] d);
      return (d >> 1) + {31'b0, d[0]};
   endfunction
endpackage

// File: rtl/clkdiv_chan.sv
// clkdiv_chan: one divider channel with shadowed divisor applied at period boundaries
module clkdiv_chan import clkdiv_pkg::*; #(
   parameter int DIV_W = 16,
   parameter int DEFAULT_DIV = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             sync,
   input  logic             wr,
   input  logic [DIV_W-1:0] wr_div,
   output logic             clk_out,
   output logic             tick,
   output logic             pend
);
   localparam logic [DIV_W-1:0] DEF = DIV_W'(DEFAULT_DIV);
   localparam logic [DIV_W-1:0] ONE = DIV_W'(1);
   logic [DIV_W-1:0] cnt_q, cnt_d, div_act_q, div_act_d, div_sh_q, div_sh_d, cnt_n, d_nx;
   logic pend_q, pend_d, clk_out_q, clk_out_d, tick_q, tick_d, apply;
   ch_state_t state;
   // next period position, shadow apply (boundary in RUN, immediate in STOP) and output decode
   always_comb begin
      state = (en && div_act_q >= DIV_W'(DIV_MIN)) ? RUN : STOP;
      cnt_n = (sync || cnt_q == div_act_q - ONE) ? '0 : cnt_q + ONE;
      apply = pend_q && (state == STOP || cnt_n == '0);
      d_nx = apply ? div_sh_q : div_act_q;
      div_act_d = d_nx;
      cnt_d = (state == RUN) ? cnt_n : d_nx - ONE;
      clk_out_d = (state == RUN) && (32'(cnt_n) < half_up(32'(d_nx)));
      tick_d = (state == RUN) && (cnt_n == '0);
      div_sh_d = wr ? wr_div : div_sh_q;
      pend_d = wr || (pend_q && !apply);
   end
   // channel state registers; a write in an apply cycle keeps the flag set for the next boundary
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         cnt_q <= DEF - ONE;
         div_act_q <= DEF;
         div_sh_q <= DEF;
         pend_q <= 1'b0;
         clk_out_q <= 1'b0;
         tick_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         div_act_q <= div_act_d;
         div_sh_q <= div_sh_d;
         pend_q <= pend_d;
         clk_out_q <= clk_out_d;
         tick_q <= tick_d;
      end
   end
   assign clk_out = clk_out_q;
   assign tick = tick_q;
   assign pend = pend_q;
endmodule

// File: rtl/clkdiv_multi.sv
// clkdiv_multi: array of programmable clock divider channels with a shared write port
module clkdiv_multi import clkdiv_pkg::*; #(
   parameter int CHANNELS = 4,
   parameter int DIV_W = 16,
   parameter int DEFAULT_DIV = 4,
   localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [CHANNELS-1:0] en,
   input  logic                sync,
   input  logic                wr_en,
   input  logic [CW-1:0]       wr_chan,
   input  logic [DIV_W-1:0]    wr_div,
   output logic [CHANNELS-1:0] clk_out,
   output logic [CHANNELS-1:0] tick,
   output logic [CHANNELS-1:0] pend
);
   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      clkdiv_chan #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_chan (
         .clk(clk),
         .clr(clr),
         .en(en[g]),
         .sync(sync),
         .wr(wr_en && (32'(wr_chan) == g)),
         .wr_div(wr_div),
         .clk_out(clk_out[g]),
         .tick(tick[g]),
         .pend(pend[g])
      );
   end
endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: scenario tasks plus randomized traffic against a phase-based reference model
module tb_clkdiv_multi;
   localparam int CH = 3;
   logic clk = 1'b0, clr = 1'b1, sync = 1'b0, wr_en = 1'b0;
   logic [CH-1:0] en = '0;
   logic [1:0] wr_chan = '0;
   logic [15:0] wr_div = '0;
   logic [CH-1:0] clk_out, tick, pend;
   int total = 0, bad = 0;
   int m_act[CH], m_sh[CH], m_ph[CH];
   bit m_clk[CH], m_tick[CH], m_pend[CH];

   clkdiv_multi #(.CHANNELS(CH), .DIV_W(16), .DEFAULT_DIV(4)) dut (
      .clk(clk), .clr(clr), .en(en), .sync(sync), .wr_en(wr_en), .wr_chan(wr_chan),
      .wr_div(wr_div), .clk_out(clk_out), .tick(tick), .pend(pend)
   );

   always #5 clk = ~clk;

   task automatic mreset();
      for (int c = 0; c < CH; c++) begin
         m_act[c] = 4; m_sh[c] = 4; m_ph[c] = 3;
         m_clk[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
      end
   endtask

   function automatic logic [3*CH-1:0] mexp();
      logic [3*CH-1:0] v;
      for (int c = 0; c < CH; c++) begin
         v[c] = m_clk[c]; v[CH+c] = m_tick[c]; v[2*CH+c] = m_pend[c];
      end
      return v;
   endfunction

   // one clock edge: advance the model with the inputs seen at the edge, then settle
   task automatic step();
      bit run;
      @(posedge clk);
      if (clr) mreset();
      else for (int c = 0; c < CH; c++) begin
         run = en[c] && m_act[c] >= 2;
         if (run) begin
            m_ph[c] = sync ? 0 : (m_ph[c] + 1) % m_act[c];
            if (m_ph[c] == 0 && m_pend[c]) begin m_act[c] = m_sh[c]; m_pend[c] = 0; end
            m_clk[c] = m_ph[c] < (m_act[c] + 1) / 2;
            m_tick[c] = m_ph[c] == 0;
         end else begin
            if (m_pend[c]) begin m_act[c] = m_sh[c]; m_pend[c] = 0; end
            m_ph[c] = m_act[c] - 1; m_clk[c] = 0; m_tick[c] = 0;
         end
         if (wr_en && wr_chan == 2'(c)) begin m_sh[c] = int'(wr_div); m_pend[c] = 1; end
      end
      #1;
   endtask

   task automatic test_reset();
      mreset();
      #1;
      total++; if ({pend, tick, clk_out} !== '0) begin bad++; $display("FAIL reset_async got %b want 0", {pend, tick, clk_out}); end
      step(); step();
      total++; if ({pend, tick, clk_out} !== mexp()) begin bad++; $display("FAIL reset_hold got %b want %b", {pend, tick, clk_out}, mexp()); end
      clr = 1'b0;
   endtask

   task automatic test_basic();
      en = 3'b001;
      for (int k = 0; k < 8; k++) begin
         step();
         total++; if (clk_out[0] !== (k % 4 < 2) || tick[0] !== (k % 4 == 0) || clk_out[2:1] !== 2'b00 || tick[2:1] !== 2'b00) begin
            bad++; $display("FAIL basic k=%0d clk_out=%b tick=%b want clk0=%0d tick0=%0d", k, clk_out, tick, k % 4 < 2, k % 4 == 0);
         end
         total++; if ({pend, tick, clk_out} !== mexp()) begin bad++; $display("FAIL basic_model got %b want %b", {pend, tick, clk_out}, mexp()); end
      end
   endtask

   task automatic test_ratio_change();
      int pcnt = 0;
      wr_en = 1'b1; wr_chan = 2'd1; wr_div = 16'd6; step(); wr_en = 1'b0;
      total++; if (pend[1] !== 1'b1) begin bad++; $display("FAIL ratio_pend_stop got %b want 1", pend[1]); end
      step();
      total++; if (pend[1] !== 1'b0) begin bad++; $display("FAIL ratio_apply_stop got %b want 0", pend[1]); end
      en = 3'b011; step();
      total++; if (tick[1] !== 1'b1) begin bad++; $display("FAIL ratio_start_tick got %b want 1", tick[1]); end
      step(); step();
      wr_en = 1'b1; wr_div = 16'd3; step(); wr_en = 1'b0;
      for (int k = 0; k < 8 && pend[1]; k++) begin pcnt++; step(); end
      total++; if (pcnt != 3) begin bad++; $display("FAIL ratio_pend_len got %0d want 3", pcnt); end
      for (int k = 0; k < 6; k++) begin
         total++; if (clk_out[1] !== (k % 3 < 2) || tick[1] !== (k % 3 == 0)) begin
            bad++; $display("FAIL ratio_pattern k=%0d clk=%b tick=%b want %0d %0d", k, clk_out[1], tick[1], k % 3 < 2, k % 3 == 0);
         end
         total++; if ({pend, tick, clk_out} !== mexp()) begin bad++; $display("FAIL ratio_model got %b want %b", {pend, tick, clk_out}, mexp()); end
         step();
      end
   endtask

   task automatic test_stop_resume();
      int n = 0;
      wr_en = 1'b1; wr_chan = 2'd1; wr_div = 16'd1; step(); wr_en = 1'b0;
      for (int k = 0; k < 6 && pend[1]; k++) step();
      total++; if (pend[1] !== 1'b0) begin bad++; $display("FAIL stop_boundary pend got %b want 0", pend[1]); end
      step();
      for (int k = 0; k < 4; k++) begin
         total++; if (clk_out[1] !== 1'b0 || tick[1] !== 1'b0) begin bad++; $display("FAIL stop_quiet clk=%b tick=%b want 0 0", clk_out[1], tick[1]); end
         total++; if ({pend, tick, clk_out} !== mexp()) begin bad++; $display("FAIL stop_model got %b want %b", {pend, tick, clk_out}, mexp()); end
         step();
      end
      wr_en = 1'b1; wr_div = 16'd5; step(); wr_en = 1'b0;
      while (!tick[1] && n < 4) begin step(); n++; end
      total++; if (tick[1] !== 1'b1) begin bad++; $display("FAIL resume_timeout tick got %b want 1", tick[1]); end
      for (int k = 0; k < 5; k++) begin
         total++; if (clk_out[1] !== (k < 3)) begin bad++; $display("FAIL resume_duty k=%0d got %b want %0d", k, clk_out[1], k < 3); end
         total++; if ({pend, tick, clk_out} !== mexp()) begin bad++; $display("FAIL resume_model got %b want %b", {pend, tick, clk_out}, mexp()); end
         step();
      end
   endtask

   task automatic test_sync();
      wr_en = 1'b1; wr_chan = 2'd1; wr_div = 16'd6; step(); wr_en = 1'b0;
      repeat (8) step();
      repeat ($urandom_range(1, 4)) step();
      sync = 1'b1; step(); sync = 1'b0;
      total++; if (tick[1:0] !== 2'b11) begin bad++; $display("FAIL sync_align got %b want 11", tick[1:0]); end
      for (int k = 1; k <= 4; k++) begin
         step();
         total++; if (tick[1:0] !== ((k == 4) ? 2'b01 : 2'b00)) begin bad++; $display("FAIL sync_free k=%0d got %b", k, tick[1:0]); end
         total++; if ({pend, tick, clk_out} !== mexp()) begin bad++; $display("FAIL sync_model got %b want %b", {pend, tick, clk_out}, mexp()); end
      end
   endtask

   task automatic test_write_stop();
      wr_en = 1'b1; wr_chan = 2'd3; wr_div = 16'd9; step();
      total++; if (pend !== 3'b000) begin bad++; $display("FAIL bad_chan_ignored got %b want 000", pend); end
      wr_chan = 2'd2; wr_div = 16'd7; step(); wr_en = 1'b0;
      total++; if (pend[2] !== 1'b1) begin bad++; $display("FAIL wstop_pend got %b want 1", pend[2]); end
      step();
      total++; if ({pend[2], tick[2], clk_out[2]} !== 3'b000) begin bad++; $display("FAIL wstop_apply got %b want 000", {pend[2], tick[2], clk_out[2]}); end
      en = 3'b111; step();
      total++; if ({pend[2], tick[2], clk_out[2]} !== 3'b011) begin bad++; $display("FAIL wstop_first got %b want 011", {pend[2], tick[2], clk_out[2]}); end
      for (int k = 1; k <= 7; k++) begin
         step();
         total++; if (tick[2] !== (k == 7) || clk_out[2] !== (k < 4 || k == 7)) begin
            bad++; $display("FAIL wstop_run k=%0d tick=%b clk=%b", k, tick[2], clk_out[2]);
         end
         total++; if ({pend, tick, clk_out} !== mexp()) begin bad++; $display("FAIL wstop_model got %b want %b", {pend, tick, clk_out}, mexp()); end
      end
   endtask

   task automatic test_clr();
      repeat (3) step();
      #2 clr = 1'b1;
      #1;
      total++; if ({pend, tick, clk_out} !== '0) begin bad++; $display("FAIL clr_async got %b want 0", {pend, tick, clk_out}); end
      mreset();
      step();
      clr = 1'b0;
      for (int k = 0; k < 9; k++) begin
         step();
         total++; if (tick !== ((k % 4 == 0) ? 3'b111 : 3'b000)) begin bad++; $display("FAIL clr_default k=%0d got %b", k, tick); end
         total++; if ({pend, tick, clk_out} !== mexp()) begin bad++; $display("FAIL clr_model got %b want %b", {pend, tick, clk_out}, mexp()); end
      end
   endtask

   task automatic test_random();
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 15) == 0) en = 3'($urandom_range(0, 7));
         sync = ($urandom_range(0, 19) == 0);
         wr_en = ($urandom_range(0, 3) == 0);
         wr_chan = 2'($urandom_range(0, 3));
         wr_div = 16'($urandom_range(0, 9));
         step();
         total++; if ({pend, tick, clk_out} !== mexp()) begin bad++; $display("FAIL random k=%0d got %b want %b", k, {pend, tick, clk_out}, mexp()); end
      end
      sync = 1'b0; wr_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_ratio_change();
      test_stop_resume();
      test_sync();
      test_write_stop();
      test_clr();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
